// File: rtl/cma_equalizer_if.sv
// Sample-stream bundle for the CMA equaliser: input samples with qualifier and
// enable on one side, equalised samples, strobe and error power on the other.
interface cma_equalizer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         enable;
    logic signed [DATA_WIDTH-1:0] data_in_real;
    logic signed [DATA_WIDTH-1:0] data_in_imag;
    logic                         data_valid;
    logic signed [DATA_WIDTH-1:0] data_out_real;
    logic signed [DATA_WIDTH-1:0] data_out_imag;
    logic                         data_out_valid;
    logic [31:0]                  error_magnitude;

    // Sample source / result sink (e.g. front end or testbench)
    modport master (
        output enable, data_in_real, data_in_imag, data_valid,
        input  data_out_real, data_out_imag, data_out_valid, error_magnitude
    );

    // Equaliser side
    modport slave (
        input  enable, data_in_real, data_in_imag, data_valid,
        output data_out_real, data_out_imag, data_out_valid, error_magnitude
    );
endinterface

// File: rtl/cma_equalizer.sv
// Blind adaptive complex FIR equaliser (Constant Modulus Algorithm).
// One accepted sample shifts the delay line; the following cycle filters it with
// the current weights, registers the output and error power, and updates all taps.
module cma_equalizer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_TAPS   = 11,
    parameter int FRAC_BITS  = 12,
    parameter int STEP_SIZE  = 41,
    parameter int R2         = 512
) (
    input logic            clk,
    input logic            rst,
    cma_equalizer_if.slave bus
);
    localparam int CentreTap = NUM_TAPS / 2;

    // 64-bit working width comfortably covers the >=40-bit accumulator and all products
    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic signed [63:0]           wide_t;

    localparam wide_t   SatMax    = (wide_t'(1) <<< (DATA_WIDTH - 1)) - wide_t'(1);
    localparam wide_t   SatMin    = -(wide_t'(1) <<< (DATA_WIDTH - 1));
    localparam sample_t WeightOne = sample_t'(wide_t'(1) <<< FRAC_BITS);

    // Clamp a wide signed value into the sample range instead of wrapping
    function automatic sample_t sat_dw(input wide_t v);
        if (v > SatMax) return sample_t'(SatMax);
        if (v < SatMin) return sample_t'(SatMin);
        return sample_t'(v);
    endfunction

    sample_t     x_r_q [NUM_TAPS];
    sample_t     x_i_q [NUM_TAPS];
    sample_t     x_r_d [NUM_TAPS];
    sample_t     x_i_d [NUM_TAPS];
    sample_t     w_r_q [NUM_TAPS];
    sample_t     w_i_q [NUM_TAPS];
    sample_t     w_r_d [NUM_TAPS];
    sample_t     w_i_d [NUM_TAPS];
    sample_t     w_r_upd [NUM_TAPS];
    sample_t     w_i_upd [NUM_TAPS];
    wide_t       g_r [NUM_TAPS];
    wide_t       g_i [NUM_TAPS];
    logic        pend_q, pend_d;
    sample_t     out_r_q, out_r_d;
    sample_t     out_i_q, out_i_d;
    logic        valid_q, valid_d;
    logic [31:0] err_q, err_d;

    wide_t       acc_r, acc_i, pwr;
    sample_t     y_r, y_i, disp, e_r, e_i;
    logic [31:0] err_mag;
    logic        accept;

    assign accept = bus.enable && bus.data_valid;

    // Filter, CMA error and per-tap gradient step, all from the current registers
    always_comb begin
        acc_r = '0;
        acc_i = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            acc_r = acc_r + wide_t'(w_r_q[k]) * wide_t'(x_r_q[k])
                          - wide_t'(w_i_q[k]) * wide_t'(x_i_q[k]);
            acc_i = acc_i + wide_t'(w_r_q[k]) * wide_t'(x_i_q[k])
                          + wide_t'(w_i_q[k]) * wide_t'(x_r_q[k]);
        end
        y_r  = sat_dw(acc_r >>> FRAC_BITS);
        y_i  = sat_dw(acc_i >>> FRAC_BITS);
        pwr  = (wide_t'(y_r) * wide_t'(y_r) + wide_t'(y_i) * wide_t'(y_i)) >>> FRAC_BITS;
        disp = sat_dw(wide_t'(R2) - pwr);
        e_r  = sat_dw((wide_t'(y_r) * wide_t'(disp)) >>> FRAC_BITS);
        e_i  = sat_dw((wide_t'(y_i) * wide_t'(disp)) >>> FRAC_BITS);
        err_mag = 32'(wide_t'(e_r) * wide_t'(e_r) + wide_t'(e_i) * wide_t'(e_i));
        for (int k = 0; k < NUM_TAPS; k++) begin
            // e * conj(x[k])
            g_r[k] = (wide_t'(e_r) * wide_t'(x_r_q[k]) + wide_t'(e_i) * wide_t'(x_i_q[k]))
                     >>> FRAC_BITS;
            g_i[k] = (wide_t'(e_i) * wide_t'(x_r_q[k]) - wide_t'(e_r) * wide_t'(x_i_q[k]))
                     >>> FRAC_BITS;
            w_r_upd[k] = sat_dw(wide_t'(w_r_q[k])
                                + ((wide_t'(STEP_SIZE) * g_r[k]) >>> FRAC_BITS));
            w_i_upd[k] = sat_dw(wide_t'(w_i_q[k])
                                + ((wide_t'(STEP_SIZE) * g_i[k]) >>> FRAC_BITS));
        end
    end

    // Next state: shift on accept, commit result and weights one cycle later
    always_comb begin
        x_r_d   = x_r_q;
        x_i_d   = x_i_q;
        w_r_d   = w_r_q;
        w_i_d   = w_i_q;
        out_r_d = out_r_q;
        out_i_d = out_i_q;
        err_d   = err_q;
        valid_d = 1'b0;
        pend_d  = accept;
        if (accept) begin
            for (int k = 1; k < NUM_TAPS; k++) begin
                x_r_d[k] = x_r_q[k-1];
                x_i_d[k] = x_i_q[k-1];
            end
            x_r_d[0] = bus.data_in_real;
            x_i_d[0] = bus.data_in_imag;
        end
        // A pending compute completes even if enable has since dropped
        if (pend_q) begin
            out_r_d = y_r;
            out_i_d = y_i;
            err_d   = err_mag;
            valid_d = 1'b1;
            w_r_d   = w_r_upd;
            w_i_d   = w_i_upd;
        end
    end

    // State registers with synchronous reset; weights start as a unit centre tap
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                x_r_q[k] <= '0;
                x_i_q[k] <= '0;
                w_r_q[k] <= (k == CentreTap) ? WeightOne : '0;
                w_i_q[k] <= '0;
            end
            pend_q  <= 1'b0;
            out_r_q <= '0;
            out_i_q <= '0;
            valid_q <= 1'b0;
            err_q   <= '0;
        end else begin
            x_r_q   <= x_r_d;
            x_i_q   <= x_i_d;
            w_r_q   <= w_r_d;
            w_i_q   <= w_i_d;
            pend_q  <= pend_d;
            out_r_q <= out_r_d;
            out_i_q <= out_i_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.data_out_real   = out_r_q;
    assign bus.data_out_imag   = out_i_q;
    assign bus.data_out_valid  = valid_q;
    assign bus.error_magnitude = err_q;
endmodule

// File: tb/tb_cma_equalizer.sv
// Directed bench for cma_equalizer: reset, passthrough, error value, converged
// hold, enable gating and adaptation on a three-tap channel.
module tb_cma_equalizer;
    localparam int MuQ  = 41;
    localparam int R2Q  = 512;

    logic clk;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   valid_total = 0;

    cma_equalizer_if #(.DATA_WIDTH(16)) bus ();

    cma_equalizer #(
        .DATA_WIDTH(16),
        .NUM_TAPS  (11),
        .FRAC_BITS (12),
        .STEP_SIZE (MuQ),
        .R2        (R2Q)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (!rst && bus.data_out_valid) valid_total <= valid_total + 1;

    int     in_r [100];
    int     in_i [100];
    longint mxr [11];
    longint mxi [11];
    longint mwr [11];
    longint mwi [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint got, input longint exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input longint v, input longint r,
                           input longint i, input longint e);
        chk({tag, ".valid"}, longint'(bus.data_out_valid), v);
        chk({tag, ".re"}, longint'(bus.data_out_real), r);
        chk({tag, ".im"}, longint'(bus.data_out_imag), i);
        chk({tag, ".err"}, longint'(bus.error_magnitude), e);
    endtask

    // One isolated sample; returns with its result on the outputs
    task automatic send(input int re, input int im);
        bus.data_in_real = 16'(re);
        bus.data_in_imag = 16'(im);
        bus.data_valid   = 1'b1;
        tick();
        bus.data_valid   = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.data_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic longint msat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 11; k++) begin
            mxr[k] = 0; mxi[k] = 0; mwr[k] = (k == 5) ? 4096 : 0; mwi[k] = 0;
        end
    endtask

    // Reference CMA step: shift sample in, filter, error, LMS-style weight update
    task automatic model_step(input longint ir, input longint ii,
                              output longint yr, output longint yi, output longint em);
        longint ar, ai, p, d, er, ei, gr, gi;
        for (int k = 10; k > 0; k--) begin
            mxr[k] = mxr[k-1];
            mxi[k] = mxi[k-1];
        end
        mxr[0] = ir;
        mxi[0] = ii;
        ar = 0;
        ai = 0;
        for (int k = 0; k < 11; k++) begin
            ar += mwr[k] * mxr[k] - mwi[k] * mxi[k];
            ai += mwr[k] * mxi[k] + mwi[k] * mxr[k];
        end
        yr = msat(ar >>> 12);
        yi = msat(ai >>> 12);
        p  = (yr * yr + yi * yi) >>> 12;
        d  = msat(longint'(R2Q) - p);
        er = msat((yr * d) >>> 12);
        ei = msat((yi * d) >>> 12);
        em = er * er + ei * ei;
        for (int k = 0; k < 11; k++) begin
            gr = (er * mxr[k] + ei * mxi[k]) >>> 12;
            gi = (ei * mxr[k] - er * mxi[k]) >>> 12;
            mwr[k] = msat(mwr[k] + ((longint'(MuQ) * gr) >>> 12));
            mwi[k] = msat(mwi[k] + ((longint'(MuQ) * gi) >>> 12));
        end
    endtask

    initial begin
        longint yr, yi, em, sum_first, sum_last;
        int     s_r [3];
        int     s_i [3];
        int     xr, xi, base;

        rst = 1'b1;
        bus.enable = 1'b1;
        bus.data_valid = 1'b0;
        bus.data_in_real = '0;
        bus.data_in_imag = '0;

        // 1: reset for three cycles, then idle with no spurious valid
        tick(); tick(); tick();
        chk_out("reset", 0, 0, 0, 0);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("idle.valid", longint'(bus.data_out_valid), 0);
        end

        // 2: impulse emerges at the centre tap, five samples later, with zero error
        do_reset();
        send(1024, 1024);
        chk_out("pass0", 1, 0, 0, 0);
        for (int n = 1; n < 5; n++) begin
            send(0, 0);
            chk_out("pass_zero", 1, 0, 0, 0);
        end
        send(0, 0);
        chk_out("pass5", 1, 1024, 1024, 0);

        // 3: |y|^2 = 0.25 against R2 = 0.125 -> d = -512, e = -256, |e|^2 = 65536
        do_reset();
        send(2048, 0);
        chk_out("err0", 1, 0, 0, 0);
        for (int n = 1; n < 5; n++) send(0, 0);
        send(0, 0);
        chk_out("err5", 1, 2048, 0, 65536);

        // 4: constant-modulus symbols back-to-back through ideal channel stay exact
        do_reset();
        for (int n = 0; n < 100; n++) begin
            in_r[n] = ($urandom_range(0, 1) != 0) ? 1024 : -1024;
            in_i[n] = ($urandom_range(0, 1) != 0) ? 1024 : -1024;
        end
        for (int n = 0; n < 100; n++) begin
            bus.data_in_real = 16'(in_r[n]);
            bus.data_in_imag = 16'(in_i[n]);
            bus.data_valid   = 1'b1;
            tick();
            if (n > 0)
                chk_out("hold", 1, (n > 5) ? in_r[n-6] : 0, (n > 5) ? in_i[n-6] : 0, 0);
        end
        bus.data_valid = 1'b0;
        tick();
        chk_out("hold_last", 1, in_r[94], in_i[94], 0);

        // 5: disabled block ignores valid pulses and holds everything
        bus.enable = 1'b0;
        for (int n = 0; n < 10; n++) begin
            bus.data_in_real = 16'(int'($urandom_range(0, 4000)) - 2000);
            bus.data_in_imag = 16'(int'($urandom_range(0, 4000)) - 2000);
            bus.data_valid   = 1'b1;
            tick();
            chk_out("disabled", 0, in_r[94], in_i[94], 0);
        end
        bus.data_valid = 1'b0;
        bus.enable = 1'b1;
        bus.data_in_real = 16'(1024);
        bus.data_in_imag = 16'(-1024);
        bus.data_valid   = 1'b1;
        tick();
        // enable drops with a compute pending; the result must still appear
        bus.data_valid = 1'b0;
        bus.enable = 1'b0;
        tick();
        chk_out("resume", 1, in_r[95], in_i[95], 0);
        bus.enable = 1'b1;
        tick();
        chk("resume_strobe", longint'(bus.data_out_valid), 0);

        // 6: channel h = [0.8, 0.4, 0.2], one symbol every four cycles
        do_reset();
        model_reset();
        base = valid_total;
        sum_first = 0;
        sum_last = 0;
        s_r = '{0, 0, 0};
        s_i = '{0, 0, 0};
        for (int n = 0; n < 200; n++) begin
            s_r[2] = s_r[1]; s_r[1] = s_r[0];
            s_i[2] = s_i[1]; s_i[1] = s_i[0];
            s_r[0] = ($urandom_range(0, 1) != 0) ? 1024 : -1024;
            s_i[0] = ($urandom_range(0, 1) != 0) ? 1024 : -1024;
            xr = (3277 * s_r[0] + 1638 * s_r[1] + 819 * s_r[2]) >>> 12;
            xi = (3277 * s_i[0] + 1638 * s_i[1] + 819 * s_i[2]) >>> 12;
            model_step(longint'(xr), longint'(xi), yr, yi, em);
            if (n < 50) sum_first += em;
            if (n >= 150) sum_last += em;
            send(xr, xi);
            chk_out("chan", 1, yr, yi, em);
            tick();
            tick();
        end
        chk("chan_valid_count", longint'(valid_total - base), 200);
        $display("channel run: mean |e|^2 first 50 = %0d, last 50 = %0d",
                 sum_first / 50, sum_last / 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
